// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 pipeline widths, ALU opcodes and ID/EX stage types.
package rv_pkg;
    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;
    localparam logic [CTRL_W-1:0] ALU_SLL = 3'b110;
    localparam logic [CTRL_W-1:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {FWD_RF, FWD_MEMWB, FWD_EXMEM} fwd_sel_t;
    typedef enum logic {EMPTY, FULL} stage_state_t;
endpackage

// File: rtl/id_ex_stage_fwd_resolve.sv
// fwd_resolve: picks one source operand from EX/MEM, MEM/WB or the register file,
// nearest producer first; x0 always reads the register file.
module fwd_resolve
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int RA_W = rv_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] value
);
    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (rs_addr != '0 && exmem_reg_write && exmem_rd == rs_addr)
            sel = FWD_EXMEM;
        else if (rs_addr != '0 && memwb_reg_write && memwb_rd == rs_addr)
            sel = FWD_MEMWB;
        value = sel == FWD_EXMEM ? exmem_result :
                sel == FWD_MEMWB ? memwb_result : rs_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, valid/ready handshake with flush.
// Define RV_FWD_EN to enable operand forwarding and MEM/WB snooping while stalled.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int RA_W   = rv_pkg::RA_W,
    parameter int CTRL_W = rv_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   rs1_addr,
    input  logic [RA_W-1:0]   rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic              alu_src,
    input  logic [CTRL_W-1:0] alu_ctrl_in,
    input  logic [RA_W-1:0]   rd_addr_in,
    input  logic              reg_write_in,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   store_data,
    output logic [RA_W-1:0]   rd_addr_out,
    output logic              reg_write_out
);
    stage_state_t    state, state_nx;
    logic            capture;
    logic [RA_W-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_q;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            alu_src_q;
    logic            snoop1, snoop2;

    assign out_valid = state == FULL;
    assign in_ready  = state == EMPTY || out_ready;
    assign capture   = in_valid && in_ready && !flush;

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = EMPTY;
        else if (capture)
            state_nx = FULL;
        else if (out_ready)
            state_nx = EMPTY;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= EMPTY;
        else
            state <= state_nx;

`ifdef RV_FWD_EN
    fwd_resolve #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_addr(rs1_addr), .rs_data(rs1_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .value(rs1_fwd)
    );
    fwd_resolve #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_addr(rs2_addr), .rs_data(rs2_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .value(rs2_fwd)
    );
    // A stalled operand only needs MEM/WB: anything in EX/MEM now reaches MEM/WB before we leave.
    assign snoop1 = state == FULL && !out_ready && memwb_reg_write && memwb_rd == rs1_q && rs1_q != '0;
    assign snoop2 = state == FULL && !out_ready && memwb_reg_write && memwb_rd == rs2_q && rs2_q != '0;
`else
    logic unused_fwd;
    assign rs1_fwd    = rs1_data;
    assign rs2_fwd    = rs2_data;
    assign snoop1     = 1'b0;
    assign snoop2     = 1'b0;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, rs1_q, rs2_q};
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rs1_q         <= '0;
            rs2_q         <= '0;
            rs1_val       <= '0;
            rs2_val       <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            alu_ctrl      <= '0;
            rd_addr_out   <= '0;
            reg_write_out <= 1'b0;
        end else if (capture) begin
            rs1_q         <= rs1_addr;
            rs2_q         <= rs2_addr;
            rs1_val       <= rs1_fwd;
            rs2_val       <= rs2_fwd;
            imm_q         <= imm;
            alu_src_q     <= alu_src;
            alu_ctrl      <= alu_ctrl_in;
            rd_addr_out   <= rd_addr_in;
            reg_write_out <= reg_write_in;
        end else begin
            if (snoop1)
                rs1_val <= memwb_result;
            if (snoop2)
                rs2_val <= memwb_result;
        end

    assign alu_a      = rs1_val;
    assign alu_b      = alu_src_q ? imm_q : rs2_val;
    assign store_data = rs2_val;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of handshake, flush, reset, forwarding and stall snoop.
// Forwarding expectations follow RV_FWD_EN so the bench matches either build.
module tb_id_ex_stage;
    import rv_pkg::*;

`ifdef RV_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [RA_W-1:0]   rs1_addr, rs2_addr, rd_addr_in, exmem_rd, memwb_rd, rd_addr_out;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm, exmem_result, memwb_result;
    logic              alu_src, reg_write_in, flush, exmem_reg_write, memwb_reg_write;
    logic [CTRL_W-1:0] alu_ctrl_in, alu_ctrl;
    logic              out_valid, out_ready, reg_write_out;
    logic [XLEN-1:0]   alu_a, alu_b, store_data;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .alu_src(alu_src), .alu_ctrl_in(alu_ctrl_in),
        .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .store_data(store_data),
        .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0;
        imm = '0; alu_src = 1'b0; alu_ctrl_in = '0; rd_addr_in = '0; reg_write_in = 1'b0;
        flush = 1'b0; exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // plain ADD with immediate
        in_valid = 1'b1; rs1_addr = 5'd3; rs1_data = 32'd5; rs2_addr = 5'd4; rs2_data = 32'h44;
        imm = 32'd7; alu_src = 1'b1; alu_ctrl_in = ALU_ADD; rd_addr_in = 5'd9; reg_write_in = 1'b1;
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("add_store", store_data, 32'h44);
        chk("add_rd", {27'd0, rd_addr_out}, 32'd9);
        chk("add_rw", {31'd0, reg_write_out}, 32'd1);

        // both stages write x3: EX/MEM wins
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h20;
        alu_src = 1'b0; alu_ctrl_in = ALU_SUB;
        tick();
        chk("fwd_exmem_a", alu_a, FWD ? 32'h10 : 32'd5);
        chk("fwd_exmem_b", alu_b, 32'h44);
        chk("sub_ctrl", {29'd0, alu_ctrl}, 32'd1);

        exmem_reg_write = 1'b0;
        tick();
        chk("fwd_memwb_a", alu_a, FWD ? 32'h20 : 32'd5);

        // x0 never forwards
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        rs1_addr = 5'd0; rs1_data = 32'h99;
        tick();
        chk("fwd_x0_a", alu_a, 32'h99);

        // stall with MEM/WB snoop on rs2=x4
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        rs1_addr = 5'd1; rs1_data = 32'd1; rs2_addr = 5'd4; rs2_data = 32'h44; alu_src = 1'b0;
        tick();
        chk("stall_cap_b", alu_b, 32'h44);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("stall1_valid", {31'd0, out_valid}, 32'd1);
        chk("stall1_b", alu_b, 32'h44);
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hABCD;
        tick();
        memwb_reg_write = 1'b0; rs2_data = 32'h55;
        chk("stall2_b", alu_b, FWD ? 32'hABCD : 32'h44);
        tick();
        chk("stall3_b", alu_b, FWD ? 32'hABCD : 32'h44);
        chk("stall3_store", store_data, FWD ? 32'hABCD : 32'h44);
        chk("stall3_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("release_drain", {31'd0, out_valid}, 32'd0);

        // flush while FULL kills incoming instruction
        in_valid = 1'b1; rs1_data = 32'h11;
        tick();
        chk("pre_flush_a", alu_a, 32'h11);
        flush = 1'b1; rs1_data = 32'h77;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; rs1_data = 32'h66;
        tick();
        chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
        chk("post_flush_a", alu_a, 32'h66);

        // back-to-back stream
        alu_src = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rs1_data = 32'h100 + i; imm = 32'h200 + i; alu_ctrl_in = i[2:0];
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_a", alu_a, 32'h100 + i);
            chk("stream_b", alu_b, 32'h200 + i);
            chk("stream_ctrl", {29'd0, alu_ctrl}, i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        // async reset in the middle of a stall
        in_valid = 1'b1; rs1_data = 32'h5A; alu_ctrl_in = ALU_XOR;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_a", alu_a, 32'd0);
        chk("async_rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32 core. Sits directly upstream of the ALU and drives its A, B and ALUControl inputs from registered state.
- Captures decoded operands under a valid/ready handshake and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- While stalled, watches MEM/WB writebacks so held operands never go stale.
- Supports flush for branch redirect.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width
- CTRL_W, 3, ALU control width, matching the ALU opcode field

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- rs1_addr, rs2_addr  in  RA_W  source register indices
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm  in  XLEN  sign-extended immediate
- alu_src  in  1  1: B operand = imm; 0: B = rs2
- alu_ctrl_in  in  CTRL_W  ALU opcode
- rd_addr_in  in  RA_W  destination register
- reg_write_in  in  1  instruction writes rd
- flush  in  1  kill held and incoming instruction
- exmem_reg_write, exmem_rd, exmem_result  in  1/RA_W/XLEN  EX/MEM forwarding source
- memwb_reg_write, memwb_rd, memwb_result  in  1/RA_W/XLEN  MEM/WB forwarding source
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream (EX/MEM) accepts
- alu_a, alu_b  out  XLEN  ALU operands
- alu_ctrl  out  CTRL_W  ALU opcode
- store_data  out  XLEN  forwarded rs2, always the register value, never imm
- rd_addr_out, reg_write_out  out  RA_W/1  destination info

Behaviour:
- Reset (rst low, async): out_valid=0. All held data, alu_ctrl, rd_addr_out and reg_write_out are 0. in_ready=1 once rst is released.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - Capture occurs on a rising edge when in_valid && in_ready && !flush. out_valid=1 on the next cycle.
  - Latency is 1 cycle.
  - If out_valid && out_ready && no capture, out_valid goes 0.
- Flush: has priority over everything. Next cycle out_valid=0 and no capture, even if in_valid=1. Held data may stay but is don't-care.
- Forwarding at capture, per source rsN, in priority order:
  1. exmem_reg_write && exmem_rd==rsN && rsN!=0 → exmem_result
  2. else memwb_reg_write && memwb_rd==rsN && rsN!=0 → memwb_result
  3. else rsN_data
- Stall snoop: each cycle with out_valid && !out_ready, if memwb_reg_write && memwb_rd==held rsN && rsN!=0, the held rsN value is replaced by memwb_result. EX/MEM is not snooped while stalled.
- x0 is never forwarded. Forwarded value for x0 is always rsN_data.
- Outputs:
  - alu_a = held rs1 value.
  - alu_b = alu_src ? held imm : held rs2 value.
  - alu_b is a mux on registered state only; no input-to-output combinational path except in_ready.
- State: EMPTY (out_valid=0) / FULL (out_valid=1).
  - EMPTY→FULL on capture.
  - FULL→FULL on stall, or on accept with simultaneous capture.
  - FULL→EMPTY on accept without capture, or on flush.
- Reset mid-stall drops the instruction. No partial state survives.

Optional Feature:
- RV_FWD_EN
  - Defined: forwarding and stall snoop as above.
  - Undefined: operands come straight from rs1_data/rs2_data; the exmem_* and memwb_* ports are present but ignored. Software or the hazard unit must insert bubbles.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN, RA_W, CTRL_W
  - ALU opcode constants: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLL=110, SRL=111
  - fwd_sel_t enum: FWD_RF, FWD_MEMWB, FWD_EXMEM
- Sub-module fwd_resolve: one operand's priority mux plus match logic, instantiated twice.

Test Plan:
- Reset with out_ready=1: rst low mid-transaction → out_valid=0 and alu_a=0 immediately, without a clock edge. After release, in_ready=1.
- Capture ADD with rs1=x3 (data 5), imm=7, alu_src=1, no hazard → next cycle alu_a=5, alu_b=7, alu_ctrl=000, out_valid=1.
- EX/MEM and MEM/WB both write x3 (exmem_result=0x10, memwb_result=0x20), capture with rs1=x3 → alu_a=0x10. Repeat with rs1=x0 → alu_a=rs1_data.
- out_ready=0 for 3 cycles holding rs2=x4. In cycle 2, memwb writes x4=0xABCD → alu_b and store_data=0xABCD from cycle 3. Release out_ready → single transfer.
- flush=1 together with in_valid=1 while FULL → next cycle out_valid=0, no capture. in_valid the cycle after is captured normally.
- Back-to-back stream with out_ready=1: 8 instructions in 8 cycles → 8 consecutive outputs with no bubbles and in_ready constantly 1.
